// File: rtl/scanner_pkg.sv
// rtl/scanner_pkg.sv - shared scanner state codes, 7-segment glyphs and host receiver FSM states
package scanner_pkg;

  localparam logic [2:0] ST_LOW_POWER = 3'd0;
  localparam logic [2:0] ST_STANDBY   = 3'd1;
  localparam logic [2:0] ST_SCANNING  = 3'd2;
  localparam logic [2:0] ST_IDLE      = 3'd3;
  localparam logic [2:0] ST_XFERRING  = 3'd4;
  localparam logic [2:0] ST_FLUSHING  = 3'd5;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX0   = 7'b1000000;
  localparam logic [6:0] HEX1   = 7'b1111001;
  localparam logic [6:0] HEX2   = 7'b0100100;
  localparam logic [6:0] HEX3   = 7'b0110000;
  localparam logic [6:0] HEX4   = 7'b0011001;
  localparam logic [6:0] HEX5   = 7'b0010010;
  localparam logic [6:0] HEX6   = 7'b0000010;
  localparam logic [6:0] HEX7   = 7'b1111000;
  localparam logic [6:0] HEX8   = 7'b0000000;
  localparam logic [6:0] HEX9   = 7'b0010000;
  localparam logic [6:0] HEXA   = 7'b0001000;
  localparam logic [6:0] HEXB   = 7'b0000011;
  localparam logic [6:0] HEXC   = 7'b1000110;
  localparam logic [6:0] HEXD   = 7'b0100001;
  localparam logic [6:0] HEXE   = 7'b0000110;
  localparam logic [6:0] HEXF   = 7'b0001110;
  localparam logic [6:0] HEXOFF = 7'b1111111;

  typedef enum logic [2:0] {IDLE, GRANT, WAIT, RECV, DONE} xfer_state_t;

endpackage

// File: rtl/seg7_digit.sv
// rtl/seg7_digit.sv - 4-bit value to active-low 7-segment glyph (0-9, A-F)
module seg7_digit
  import scanner_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    case (value)
      4'd0:    seg = HEX0;
      4'd1:    seg = HEX1;
      4'd2:    seg = HEX2;
      4'd3:    seg = HEX3;
      4'd4:    seg = HEX4;
      4'd5:    seg = HEX5;
      4'd6:    seg = HEX6;
      4'd7:    seg = HEX7;
      4'd8:    seg = HEX8;
      4'd9:    seg = HEX9;
      4'd10:   seg = HEXA;
      4'd11:   seg = HEXB;
      4'd12:   seg = HEXC;
      4'd13:   seg = HEXD;
      4'd14:   seg = HEXE;
      default: seg = HEXF;
    endcase
  end

endmodule

// File: rtl/host_xfer_receiver.sv
// rtl/host_xfer_receiver.sv - round-robin grant and unit counting for two scanners; HOST_XFER_RECEIVER_HEX_EN adds hex display outputs
module host_xfer_receiver
  import scanner_pkg::*;
#(
  parameter int TIMEOUT_CYC = 8,
  parameter int TOTAL_W     = 12,
  parameter int BUF_UNITS   = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               scan1_ready,
  input  logic               scan2_ready,
  input  logic [2:0]         scan1_state,
  input  logic [2:0]         scan2_state,
  input  logic [3:0]         scan1_prog,
  input  logic [3:0]         scan2_prog,
  output logic               scan1_start,
  output logic               scan2_start,
  output logic               busy,
  output logic               active_src,
  output logic [3:0]         units_rx,
  output logic [TOTAL_W-1:0] total_rx,
  output logic               xfer_done,
  output logic               err_timeout,
  output logic               err_short
`ifdef HOST_XFER_RECEIVER_HEX_EN
  ,
  output logic [6:0]         hex_src,
  output logic [6:0]         hex_tens,
  output logic [6:0]         hex_ones
`endif
);

  localparam int         TMR_W  = $clog2(TIMEOUT_CYC) + 1;
  localparam int         SUM_W  = TOTAL_W + 1;
  localparam logic [3:0] BUF_U4 = 4'(BUF_UNITS);

  xfer_state_t        state, state_nx;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic               rr_pref, rr_pref_nx;   // source that wins when both are ready
  logic [3:0]         prev_prog, prev_prog_nx;
  logic               src_nx;
  logic [3:0]         units_nx;
  logic [TOTAL_W-1:0] total_nx;
  logic               err_to_nx, err_sh_nx;
  logic [2:0]         g_state;
  logic [3:0]         g_prog;
  logic [SUM_W-1:0]   total_sum;

  assign g_state   = active_src ? scan2_state : scan1_state;
  assign g_prog    = active_src ? scan2_prog  : scan1_prog;
  assign total_sum = {1'b0, total_rx} + SUM_W'(units_rx);

  always_comb begin
    state_nx     = state;
    timer_nx     = timer;
    rr_pref_nx   = rr_pref;
    prev_prog_nx = prev_prog;
    src_nx       = active_src;
    units_nx     = units_rx;
    total_nx     = total_rx;
    err_to_nx    = err_timeout;
    err_sh_nx    = err_short;
    case (state)
      IDLE: begin
        if (scan1_ready || scan2_ready) begin
          state_nx   = GRANT;
          src_nx     = (scan1_ready && scan2_ready) ? rr_pref : scan2_ready;
          rr_pref_nx = ~src_nx;
          units_nx   = '0;
        end
      end
      GRANT: begin
        state_nx = WAIT;
        timer_nx = '0;
      end
      WAIT: begin
        if (g_state == ST_XFERRING) begin
          state_nx     = RECV;
          prev_prog_nx = g_prog;
        end else begin
          timer_nx = timer + TMR_W'(1);
          if (timer_nx == TMR_W'(TIMEOUT_CYC - 1)) begin
            err_to_nx = 1'b1;
            state_nx  = IDLE;
          end
        end
      end
      RECV: begin
        // A progress step seen in the same cycle the scanner leaves xferring still counts
        if (g_prog != prev_prog) begin
          prev_prog_nx = g_prog;
          if (units_rx != 4'hF) units_nx = units_rx + 4'd1;
        end
        if (g_state != ST_XFERRING) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
        total_nx = total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
        if (units_rx < BUF_U4) err_sh_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      rr_pref     <= 1'b0;
      prev_prog   <= '0;
      active_src  <= 1'b0;
      units_rx    <= '0;
      total_rx    <= '0;
      err_timeout <= 1'b0;
      err_short   <= 1'b0;
      scan1_start <= 1'b0;
      scan2_start <= 1'b0;
      busy        <= 1'b0;
      xfer_done   <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      rr_pref     <= rr_pref_nx;
      prev_prog   <= prev_prog_nx;
      active_src  <= src_nx;
      units_rx    <= units_nx;
      total_rx    <= total_nx;
      err_timeout <= err_to_nx;
      err_short   <= err_sh_nx;
      scan1_start <= (state_nx == GRANT) && !src_nx;
      scan2_start <= (state_nx == GRANT) && src_nx;
      busy        <= (state_nx != IDLE);
      xfer_done   <= (state_nx == DONE);
    end
  end

`ifdef HOST_XFER_RECEIVER_HEX_EN
  logic [3:0] src_val, tens_val, ones_val;
  logic [6:0] src_seg;

  assign src_val  = {3'b000, active_src} + 4'd1;
  assign tens_val = (units_rx >= 4'd10) ? 4'd1 : 4'd0;
  assign ones_val = (units_rx >= 4'd10) ? units_rx - 4'd10 : units_rx;
  assign hex_src  = busy ? src_seg : HEXOFF;

  seg7_digit u_src  (.value(src_val),  .seg(src_seg));
  seg7_digit u_tens (.value(tens_val), .seg(hex_tens));
  seg7_digit u_ones (.value(ones_val), .seg(hex_ones));
`endif

endmodule
